// File: rtl/fsm_arbiter_pkg.sv
// Shared definitions for the fsm_arbiter slice: phase encodings, default timing and FSM input width.
package fsm_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_RUN   = 2'd1,
    ARB_FLUSH = 2'd2
  } arb_state_e;

  localparam int unsigned FSM_IN_W      = 3;
  localparam int unsigned DEF_WINDOW    = 8;
  localparam int unsigned DEF_FLUSH_LEN = 8;

endpackage

// File: rtl/fsm_arbiter_rr.sv
// Combinational winner selection: round robin after ptr, or lowest index when
// FSM_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt_c,
  output logic [IDX_W-1:0] idx_c,
  output logic             any_c
);

`ifdef FSM_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  // First requester found in search order wins; search starts just after the last grant.
  always_comb begin
    logic        found;
    int unsigned cand;
    gnt_c = '0;
    idx_c = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
`ifdef FSM_ARB_FIXED_PRIO_EN
      cand = k;
`else
      cand = (32'(ptr) + k + 32'd1) % N_REQ;
`endif
      if (!found && req[IDX_W'(cand)]) begin
        found               = 1'b1;
        gnt_c[IDX_W'(cand)] = 1'b1;
        idx_c               = IDX_W'(cand);
      end
    end
  end

  assign any_c = |req;

endmodule

// File: rtl/fsm_arbiter.sv
// Shares one state_machine between N_REQ requesters: IDLE -> RUN (WINDOW cycles) -> FLUSH.
// Arbitration mode selected by FSM_ARB_FIXED_PRIO_EN (see rr_arbiter).
module fsm_arbiter
  import fsm_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned WINDOW    = DEF_WINDOW,
  parameter int unsigned FLUSH_LEN = DEF_FLUSH_LEN,
  parameter int unsigned CNT_W     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [FSM_IN_W*N_REQ-1:0] code,
  output logic [N_REQ-1:0]          gnt,
  output logic                      busy,
  output logic [FSM_IN_W-1:0]       b,
  input  logic                      outp,
  output logic                      done,
  output logic [2:0]                done_id,
  output logic [CNT_W-1:0]          hi_count
);

  localparam int unsigned IDX_W   = $clog2(N_REQ);
  localparam int unsigned CYC_MAX = (WINDOW > FLUSH_LEN) ? WINDOW : FLUSH_LEN;
  localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);

  arb_state_e           state;
  logic [CYC_W-1:0]     cyc;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     cur;
  logic [CNT_W-1:0]     hit;
  logic [CNT_W-1:0]     hit_next_c;
  logic [N_REQ-1:0]     win_onehot_c;
  logic [IDX_W-1:0]     win_idx_c;
  logic                 win_any_c;
  logic [FSM_IN_W-1:0]  win_code_c;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .req   (req),
    .ptr   (ptr),
    .gnt_c (win_onehot_c),
    .idx_c (win_idx_c),
    .any_c (win_any_c)
  );

  // Only the winner's code slice can reach b.
  always_comb begin
    win_code_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_idx_c == IDX_W'(i)) win_code_c = code[FSM_IN_W*i +: FSM_IN_W];
    end
  end

  assign hit_next_c = (outp && (hit != {CNT_W{1'b1}})) ? hit + CNT_W'(1) : hit;

  // Phase FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      cyc      <= '0;
      ptr      <= '0;
      cur      <= '0;
      hit      <= '0;
      gnt      <= '0;
      busy     <= 1'b0;
      b        <= '0;
      done     <= 1'b0;
      done_id  <= '0;
      hi_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (win_any_c) begin
            state <= ARB_RUN;
            gnt   <= win_onehot_c;
            b     <= win_code_c;
            busy  <= 1'b1;
            hit   <= '0;
            cyc   <= '0;
            cur   <= win_idx_c;
          end
        end
        ARB_RUN: begin
          hit <= hit_next_c;
          if (cyc == CYC_W'(WINDOW - 1)) begin
            state    <= ARB_FLUSH;
            gnt      <= '0;
            b        <= '0;
            done     <= 1'b1;
            done_id  <= 3'(cur);
            hi_count <= hit_next_c;
            cyc      <= '0;
          end else begin
            cyc <= cyc + CYC_W'(1);
          end
        end
        ARB_FLUSH: begin
          if (cyc == CYC_W'(FLUSH_LEN - 1)) begin
            state <= ARB_IDLE;
            busy  <= 1'b0;
            ptr   <= cur;
            cyc   <= '0;
          end else begin
            cyc <= cyc + CYC_W'(1);
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
